cic_ch_sched: RTL

CIC_CH_SCHED -- requirements
Module: cic_ch_sched

---
 rtl/cic_ch_sched_pkg.sv | 14 +
 rtl/cic_ch_sched_arb.sv | 31 +++
 rtl/cic_ch_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cic_ch_sched_pkg.sv
// Shared types and constants for the CIC channel scheduler.
package cic_ch_sched_pkg;

    localparam int unsigned CH_IDX_W = 4;
    localparam logic [15:0] CFG_DEFAULT_WORD = 16'h0007;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REQ   = 2'd2,
        ST_WAIT  = 2'd3
    } seqState_t;

endpackage

// File: rtl/cic_ch_sched_arb.sv
// Round-robin arbiter: search starts at rrPtr and wraps from NUM_REQ-1 to 0.
module cic_rr_arbiter
    import cic_ch_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 16
) (
    input  logic [NUM_REQ-1:0]  reqVec,
    input  logic [CH_IDX_W-1:0] rrPtr,
    output logic [NUM_REQ-1:0]  grantOh_c,
    output logic [CH_IDX_W-1:0] grantIdx_c,
    output logic                grantVld_c
);

    int unsigned cand;

    always_comb begin
        grantOh_c  = '0;
        grantIdx_c = '0;
        grantVld_c = 1'b0;
        cand       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rrPtr) + k) % NUM_REQ;
            if (!grantVld_c && reqVec[cand]) begin
                grantVld_c      = 1'b1;
                grantIdx_c      = CH_IDX_W'(cand);
                grantOh_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_ch_sched.sv
// Per-channel holding registers feeding a round-robin scheduler, with a
// drain/request/wait sequencer that reconfigures the downstream comb.
module cic_ch_sched
    import cic_ch_sched_pkg::*;
#(
    parameter int unsigned MIDDLE_WIDTH          = 37,
    parameter int unsigned IN_WIDTH              = 16,
    parameter int unsigned CIC_MAX_CHANNELS      = 16,
    parameter int unsigned CIC_CONFIG_DATA_WIDTH = 16,
    parameter int unsigned DRAIN_CYCLES          = 16,
    parameter int unsigned CFG_TIMEOUT           = 64
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [CIC_MAX_CHANNELS*IN_WIDTH-1:0] Ch_Data_In,
    input  logic [CIC_MAX_CHANNELS-1:0]          Ch_Data_In_Valid,
    input  logic [CIC_MAX_CHANNELS-1:0]          Ch_Enable,
    input  logic                                 Cfg_Req,
    input  logic [CIC_CONFIG_DATA_WIDTH-1:0]     Cfg_Value,
    output logic                                 Cfg_Busy,
    output logic                                 Cfg_Error,
    output logic                                 Comb_isConfig,
    output logic [CIC_CONFIG_DATA_WIDTH-1:0]     Comb_Config_Data,
    input  logic                                 Comb_isConfigACK,
    input  logic                                 Comb_isConfigDone,
    output logic [MIDDLE_WIDTH-1:0]              Data_Out,
    output logic                                 Data_Out_Valid,
    output logic [CH_IDX_W-1:0]                  Data_Out_ChIdx,
    output logic [CIC_MAX_CHANNELS-1:0]          Overrun,
    input  logic                                 Overrun_Clr
);

    localparam int unsigned EXT_W   = MIDDLE_WIDTH - IN_WIDTH;
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned TO_W    = $clog2(CFG_TIMEOUT + 1);

    logic [IN_WIDTH-1:0]         holdData [CIC_MAX_CHANNELS];
    logic [CIC_MAX_CHANNELS-1:0] holdFull, fullNext, ovrSet;
    logic [CIC_MAX_CHANNELS-1:0] reqVec, grantOh;
    logic [CH_IDX_W-1:0]         rrPtr, grantIdx;
    logic                        grantVld;
    logic [IN_WIDTH-1:0]         grantSample;

    seqState_t          state, stateNext;
    logic [DRAIN_W-1:0] drainCnt, drainCntNext;
    logic [TO_W-1:0]    toCnt, toCntNext;
    logic               cfgLatch, cfgTimeout;

    // Only the RUN state may hand out grants.
    assign reqVec      = holdFull & Ch_Enable & {CIC_MAX_CHANNELS{state == ST_RUN}};
    assign grantSample = holdData[grantIdx];

    cic_rr_arbiter #(
        .NUM_REQ(CIC_MAX_CHANNELS)
    ) uArb (
        .reqVec    (reqVec),
        .rrPtr     (rrPtr),
        .grantOh_c (grantOh),
        .grantIdx_c(grantIdx),
        .grantVld_c(grantVld)
    );

    // Capture/overrun decision per channel; a same-cycle grant frees the slot for refill.
    always_comb begin
        fullNext = holdFull;
        ovrSet   = '0;
        for (int unsigned i = 0; i < CIC_MAX_CHANNELS; i++) begin
            if (!Ch_Enable[i]) begin
                fullNext[i] = 1'b0;
            end else if (Ch_Data_In_Valid[i]) begin
                if (holdFull[i] && !grantOh[i]) begin
                    ovrSet[i] = 1'b1;
                end else begin
                    fullNext[i] = 1'b1;
                end
            end else if (grantOh[i]) begin
                fullNext[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < CIC_MAX_CHANNELS; i++) begin
            if (Ch_Enable[i] && Ch_Data_In_Valid[i] && (!holdFull[i] || grantOh[i])) begin
                holdData[i] <= Ch_Data_In[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        toCntNext    = toCnt;
        cfgLatch     = 1'b0;
        cfgTimeout   = 1'b0;
        case (state)
            ST_RUN: begin
                if (Cfg_Req) begin
                    cfgLatch     = 1'b1;
                    drainCntNext = '0;
                    stateNext    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drainCnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    toCntNext = '0;
                    stateNext = ST_REQ;
                end else begin
                    drainCntNext = drainCnt + DRAIN_W'(1);
                end
            end
            ST_REQ: begin
                if (toCnt == TO_W'(CFG_TIMEOUT - 1)) begin
                    cfgTimeout = 1'b1;
                    stateNext  = ST_RUN;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                    if (Comb_isConfigACK) begin
                        stateNext = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (Comb_isConfigDone) begin
                    stateNext = ST_RUN;
                end else if (toCnt == TO_W'(CFG_TIMEOUT - 1)) begin
                    cfgTimeout = 1'b1;
                    stateNext  = ST_RUN;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                end
            end
            default: stateNext = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state            <= ST_RUN;
            drainCnt         <= '0;
            toCnt            <= '0;
            holdFull         <= '0;
            Overrun          <= '0;
            Cfg_Error        <= 1'b0;
            rrPtr            <= '0;
            Data_Out         <= '0;
            Data_Out_Valid   <= 1'b0;
            Data_Out_ChIdx   <= '0;
            Comb_isConfig    <= 1'b0;
            Cfg_Busy         <= 1'b0;
            Comb_Config_Data <= CIC_CONFIG_DATA_WIDTH'(CFG_DEFAULT_WORD);
        end else begin
            state          <= stateNext;
            drainCnt       <= drainCntNext;
            toCnt          <= toCntNext;
            holdFull       <= fullNext;
            Overrun        <= ovrSet | (Overrun & ~{CIC_MAX_CHANNELS{Overrun_Clr}});
            Cfg_Error      <= cfgTimeout | (Cfg_Error & ~Overrun_Clr);
            Data_Out_Valid <= grantVld;
            Comb_isConfig  <= (stateNext == ST_REQ);
            Cfg_Busy       <= (stateNext != ST_RUN);
            if (cfgLatch) begin
                Comb_Config_Data <= Cfg_Value;
            end
            if (grantVld) begin
                Data_Out       <= {{EXT_W{grantSample[IN_WIDTH-1]}}, grantSample};
                Data_Out_ChIdx <= grantIdx;
                rrPtr          <= (grantIdx == CH_IDX_W'(CIC_MAX_CHANNELS - 1)) ? '0
                                                                                : grantIdx + CH_IDX_W'(1);
            end
        end
    end

endmodule
